mem_port_arbiter: RTL and testbench

// Shares the single-port RAM between two requesters: the CPU memory path (MAR/MDR fetch, ld, st)
// and a DMA/in-port loader. Fixed CPU priority with a starvation guard for DMA.

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two RAM requesters (CPU, DMA), the arbiter and the single-port RAM.
// The arbiter connects through the slave modport; the surrounding system uses master.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ack;

   logic              dma_req;
   logic              dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic [DATA_W-1:0] dma_rdata;
   logic              dma_ack;

   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_write;
   logic              ram_read;
   logic [DATA_W-1:0] ram_rdata;

   logic              busy;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ack,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      output dma_rdata, dma_ack,
      output ram_addr, ram_wdata, ram_write, ram_read,
      input  ram_rdata,
      output busy
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ack,
      output dma_req, dma_we, dma_addr, dma_wdata,
      input  dma_rdata, dma_ack,
      input  ram_addr, ram_wdata, ram_write, ram_read,
      output ram_rdata,
      input  busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: CPU has fixed priority, DMA is forced after MAX_WAIT
// consecutive CPU wins. Each access is IDLE -> ACC (strobe) -> RESP (ack, read data).
module mem_port_arbiter #(
   parameter int ADDR_W   = 9,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic                Clock,
   input  logic                Reset,
   mem_port_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   state_t            state_q, state_d;
   logic              owner_dma_q, owner_dma_d;
   logic              we_q, we_d;
   logic [3:0]        wait_cnt_q, wait_cnt_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic              ram_write_q, ram_write_d;
   logic              ram_read_q, ram_read_d;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] dma_rdata_q;

   logic              dma_win;
   logic              win_we;
   logic              resp_cpu_rd;
   logic              resp_dma_rd;

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q     <= IDLE;
         owner_dma_q <= 1'b0;
         we_q        <= 1'b0;
         wait_cnt_q  <= 4'd0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         ram_write_q <= 1'b0;
         ram_read_q  <= 1'b0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_dma_q <= owner_dma_d;
         we_q        <= we_d;
         wait_cnt_q  <= wait_cnt_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ram_write_q <= ram_write_d;
         ram_read_q  <= ram_read_d;
         if (resp_cpu_rd) cpu_rdata_q <= bus.ram_rdata;
         if (resp_dma_rd) dma_rdata_q <= bus.ram_rdata;
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_dma_d = owner_dma_q;
      we_d        = we_q;
      wait_cnt_d  = wait_cnt_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ram_write_d = ram_write_q;
      ram_read_d  = ram_read_q;
      dma_win     = 1'b0;
      win_we      = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.cpu_req || bus.dma_req) begin
               // DMA takes the port when alone or once the CPU has used up its streak
               dma_win = bus.dma_req && (!bus.cpu_req || (wait_cnt_q >= MAX_WAIT_C));
               if (dma_win) begin
                  wait_cnt_d = 4'd0;
               end else if (bus.dma_req) begin
                  wait_cnt_d = wait_cnt_q + 4'd1;
               end
               win_we      = dma_win ? bus.dma_we : bus.cpu_we;
               owner_dma_d = dma_win;
               we_d        = win_we;
               ram_addr_d  = dma_win ? bus.dma_addr  : bus.cpu_addr;
               ram_wdata_d = dma_win ? bus.dma_wdata : bus.cpu_wdata;
               ram_write_d = win_we;
               ram_read_d  = !win_we;
               state_d     = ACC;
            end
         end
         ACC: begin
            ram_write_d = 1'b0;
            ram_read_d  = 1'b0;
            state_d     = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // RESP stage: RAM data arrives this cycle, bypassed to the owner and captured at the edge
   assign resp_cpu_rd = (state_q == RESP) && !owner_dma_q && !we_q;
   assign resp_dma_rd = (state_q == RESP) &&  owner_dma_q && !we_q;

   // Acks are suppressed while Reset is low so an aborted access is never acknowledged
   assign bus.cpu_ack   = (state_q == RESP) && !owner_dma_q && Reset;
   assign bus.dma_ack   = (state_q == RESP) &&  owner_dma_q && Reset;
   assign bus.cpu_rdata = resp_cpu_rd ? bus.ram_rdata : cpu_rdata_q;
   assign bus.dma_rdata = resp_dma_rd ? bus.ram_rdata : dma_rdata_q;

   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_wdata = ram_wdata_q;
   assign bus.ram_write = ram_write_q;
   assign bus.ram_read  = ram_read_q;
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a registered-read RAM model
// and a shadow copy of written data.
module tb_mem_port_arbiter;
   localparam int ADDR_W   = 9;
   localparam int DATA_W   = 32;
   localparam int MAX_WAIT = 4;

   logic Clock = 1'b0;
   logic Reset;
   always #5 Clock = ~Clock;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   // RAM model: read data one cycle after the strobe; a bench-only port preloads words
   logic [DATA_W-1:0] mem [0:511];
   logic              tb_wr;
   logic [ADDR_W-1:0] tb_wa;
   logic [DATA_W-1:0] tb_wd;
   int unsigned       write_pulses = 0;

   always @(posedge Clock) begin
      if (tb_wr) mem[tb_wa] <= tb_wd;
      else if (bus.ram_write) mem[bus.ram_addr] <= bus.ram_wdata;
      if (bus.ram_read) bus.ram_rdata <= mem[bus.ram_addr];
      if (bus.ram_write) write_pulses <= write_pulses + 1;
   end

   int errors = 0;
   int checks = 0;

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
   endtask

   task automatic test_reset();
      Reset = 1'b0;
      idle_inputs();
      tb_wr = 1'b0; tb_wa = '0; tb_wd = '0;
      step();
      step();
      checks++;
      if ({bus.busy, bus.cpu_ack, bus.dma_ack, bus.ram_read, bus.ram_write} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl got=%b exp=00000",
                  {bus.busy, bus.cpu_ack, bus.dma_ack, bus.ram_read, bus.ram_write});
      end
      checks++;
      if (bus.ram_addr !== '0 || bus.ram_wdata !== '0) begin
         errors++;
         $display("FAIL reset_ram got addr=%h wdata=%h exp 0", bus.ram_addr, bus.ram_wdata);
      end
      checks++;
      if (bus.cpu_rdata !== '0 || bus.dma_rdata !== '0) begin
         errors++;
         $display("FAIL reset_rdata got cpu=%h dma=%h exp 0", bus.cpu_rdata, bus.dma_rdata);
      end
      Reset = 1'b1;
      tb_wr = 1'b1; tb_wa = 9'h010; tb_wd = 32'hDEADBEEF;
      step();
      tb_wr = 1'b0;
      step();
   endtask

   task automatic test_cpu_read();
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 9'h010;
      step();
      checks++;
      if (bus.ram_read !== 1'b1 || bus.ram_write !== 1'b0 || bus.ram_addr !== 9'h010 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL rd_strobe got rd=%b wr=%b addr=%h busy=%b exp 1 0 010 1",
                  bus.ram_read, bus.ram_write, bus.ram_addr, bus.busy);
      end
      checks++;
      if (bus.cpu_ack !== 1'b0) begin
         errors++;
         $display("FAIL rd_early_ack got=%b exp=0", bus.cpu_ack);
      end
      step();
      checks++;
      if (bus.cpu_ack !== 1'b1 || bus.dma_ack !== 1'b0 || bus.cpu_rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL rd_ack got ack=%b dack=%b rdata=%h exp 1 0 deadbeef",
                  bus.cpu_ack, bus.dma_ack, bus.cpu_rdata);
      end
      checks++;
      if (bus.ram_read !== 1'b0) begin
         errors++;
         $display("FAIL rd_strobe_clear got=%b exp=0", bus.ram_read);
      end
      bus.cpu_req = 1'b0;
      step();
      checks++;
      if (bus.busy !== 1'b0 || bus.cpu_ack !== 1'b0 || bus.cpu_rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL rd_done got busy=%b ack=%b rdata=%h exp 0 0 deadbeef",
                  bus.busy, bus.cpu_ack, bus.cpu_rdata);
      end
   endtask

   task automatic test_write_then_read();
      int unsigned w0;
      w0 = write_pulses;
      bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 9'h020; bus.dma_wdata = 32'h12345678;
      step();
      checks++;
      if (bus.ram_write !== 1'b1 || bus.ram_read !== 1'b0 || bus.ram_addr !== 9'h020 || bus.ram_wdata !== 32'h12345678) begin
         errors++;
         $display("FAIL wr_strobe got wr=%b rd=%b addr=%h wdata=%h exp 1 0 020 12345678",
                  bus.ram_write, bus.ram_read, bus.ram_addr, bus.ram_wdata);
      end
      step();
      checks++;
      if (bus.dma_ack !== 1'b1 || bus.cpu_ack !== 1'b0 || bus.dma_rdata !== 32'h0) begin
         errors++;
         $display("FAIL wr_ack got dack=%b cack=%b drdata=%h exp 1 0 0",
                  bus.dma_ack, bus.cpu_ack, bus.dma_rdata);
      end
      bus.dma_req = 1'b0;
      step();
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 9'h020;
      step();
      step();
      checks++;
      if (bus.cpu_ack !== 1'b1 || bus.dma_ack !== 1'b0 || bus.cpu_rdata !== 32'h12345678) begin
         errors++;
         $display("FAIL wr_readback got ack=%b dack=%b rdata=%h exp 1 0 12345678",
                  bus.cpu_ack, bus.dma_ack, bus.cpu_rdata);
      end
      bus.cpu_req = 1'b0;
      step();
      checks++;
      if (write_pulses - w0 !== 32'd1) begin
         errors++;
         $display("FAIL wr_pulses got=%0d exp=1", write_pulses - w0);
      end
   endtask

   task automatic test_simultaneous();
      int cpu_cyc;
      int dma_cyc;
      cpu_cyc = -1; dma_cyc = -1;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 9'h010;
      bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 9'h020;
      for (int c = 1; c <= 7; c++) begin
         step();
         if (bus.cpu_ack === 1'b1) begin cpu_cyc = c; bus.cpu_req = 1'b0; end
         if (bus.dma_ack === 1'b1) begin dma_cyc = c; bus.dma_req = 1'b0; end
      end
      checks++;
      if (cpu_cyc != 2 || dma_cyc != 5) begin
         errors++;
         $display("FAIL sim_order got cpu_cyc=%0d dma_cyc=%0d exp 2 5", cpu_cyc, dma_cyc);
      end
      checks++;
      if (bus.cpu_rdata !== 32'hDEADBEEF || bus.dma_rdata !== 32'h12345678) begin
         errors++;
         $display("FAIL sim_data got cpu=%h dma=%h exp deadbeef 12345678", bus.cpu_rdata, bus.dma_rdata);
      end
   endtask

   task automatic test_starvation();
      logic exp_seq [10];
      logic got_seq [10];
      int   n;
      int   both;
      n = 0; both = 0;
      for (int i = 0; i < 10; i++) begin
         exp_seq[i] = (i == 4 || i == 9);
         got_seq[i] = 1'b0;
      end
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 9'h010;
      bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 9'h020;
      for (int c = 1; c <= 30; c++) begin
         step();
         if (bus.cpu_ack === 1'b1 && bus.dma_ack === 1'b1) both++;
         if ((bus.cpu_ack === 1'b1 || bus.dma_ack === 1'b1) && n < 10) begin
            got_seq[n] = bus.dma_ack;
            n++;
         end
      end
      idle_inputs();
      step(); step(); step();
      checks++;
      if (n != 10 || both != 0) begin
         errors++;
         $display("FAIL starve_count got acks=%0d both=%0d exp 10 0", n, both);
      end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (got_seq[i] !== exp_seq[i]) begin
            errors++;
            $display("FAIL starve_grant%0d got dma=%b exp dma=%b", i, got_seq[i], exp_seq[i]);
         end
      end
   endtask

   task automatic test_reset_midflight();
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 9'h010;
      step();
      step();
      Reset = 1'b0;
      #1;
      checks++;
      if (bus.cpu_ack !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_ack got=%b exp=0", bus.cpu_ack);
      end
      step();
      checks++;
      if ({bus.busy, bus.cpu_ack, bus.dma_ack, bus.ram_read, bus.ram_write} !== 5'b0 ||
          bus.ram_addr !== '0 || bus.ram_wdata !== '0 || bus.cpu_rdata !== '0 || bus.dma_rdata !== '0) begin
         errors++;
         $display("FAIL rst_mid_clear got ctrl=%b addr=%h wdata=%h crd=%h drd=%h exp all 0",
                  {bus.busy, bus.cpu_ack, bus.dma_ack, bus.ram_read, bus.ram_write},
                  bus.ram_addr, bus.ram_wdata, bus.cpu_rdata, bus.dma_rdata);
      end
      Reset = 1'b1;
      step();
      checks++;
      if (bus.ram_read !== 1'b1 || bus.ram_addr !== 9'h010) begin
         errors++;
         $display("FAIL rst_retry_strobe got rd=%b addr=%h exp 1 010", bus.ram_read, bus.ram_addr);
      end
      step();
      checks++;
      if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL rst_retry_ack got ack=%b rdata=%h exp 1 deadbeef", bus.cpu_ack, bus.cpu_rdata);
      end
      bus.cpu_req = 1'b0;
      step();
   endtask

   task automatic test_stress();
      logic [DATA_W-1:0] shadow [16];
      logic              shadow_vld [16];
      int both, streak, max_streak, cpu_done, dma_done;
      both = 0; streak = 0; max_streak = 0; cpu_done = 0; dma_done = 0;
      for (int i = 0; i < 16; i++) shadow_vld[i] = 1'b0;
      idle_inputs();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         step();
         if (bus.cpu_ack === 1'b1 && bus.dma_ack === 1'b1) both++;
         if (bus.cpu_ack === 1'b1) begin
            cpu_done++;
            if (bus.dma_req) begin
               streak++;
               if (streak > max_streak) max_streak = streak;
            end
            if (bus.cpu_we) begin
               shadow[bus.cpu_addr[3:0]] = bus.cpu_wdata;
               shadow_vld[bus.cpu_addr[3:0]] = 1'b1;
            end else if (shadow_vld[bus.cpu_addr[3:0]]) begin
               checks++;
               if (bus.cpu_rdata !== shadow[bus.cpu_addr[3:0]]) begin
                  errors++;
                  $display("FAIL stress_cpu_rd addr=%h got=%h exp=%h",
                           bus.cpu_addr, bus.cpu_rdata, shadow[bus.cpu_addr[3:0]]);
               end
            end
            bus.cpu_req = 1'b0;
         end
         if (bus.dma_ack === 1'b1) begin
            dma_done++;
            streak = 0;
            if (bus.dma_we) begin
               shadow[bus.dma_addr[3:0]] = bus.dma_wdata;
               shadow_vld[bus.dma_addr[3:0]] = 1'b1;
            end else if (shadow_vld[bus.dma_addr[3:0]]) begin
               checks++;
               if (bus.dma_rdata !== shadow[bus.dma_addr[3:0]]) begin
                  errors++;
                  $display("FAIL stress_dma_rd addr=%h got=%h exp=%h",
                           bus.dma_addr, bus.dma_rdata, shadow[bus.dma_addr[3:0]]);
               end
            end
            bus.dma_req = 1'b0;
         end
         if (!bus.cpu_req && $urandom_range(0, 1) == 0) begin
            bus.cpu_req = 1'b1; bus.cpu_we = 1'($urandom_range(0, 1));
            bus.cpu_addr = 9'($urandom_range(0, 15)); bus.cpu_wdata = $urandom;
         end
         if (!bus.dma_req && $urandom_range(0, 1) == 0) begin
            bus.dma_req = 1'b1; bus.dma_we = 1'($urandom_range(0, 1));
            bus.dma_addr = 9'($urandom_range(0, 15)); bus.dma_wdata = $urandom;
         end
      end
      idle_inputs();
      step(); step(); step(); step();
      checks++;
      if (both != 0) begin
         errors++;
         $display("FAIL stress_both_ack got=%0d exp=0", both);
      end
      checks++;
      if (max_streak > MAX_WAIT + 1) begin
         errors++;
         $display("FAIL stress_starve got=%0d exp<=%0d", max_streak, MAX_WAIT + 1);
      end
      checks++;
      if (cpu_done < 200 || dma_done < 200) begin
         errors++;
         $display("FAIL stress_progress got cpu=%0d dma=%0d exp >=200 each", cpu_done, dma_done);
      end
   endtask

   initial begin
      test_reset();
      test_cpu_read();
      test_write_then_read();
      test_simultaneous();
      test_starvation();
      test_reset_midflight();
      test_stress();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
